// File: rtl/magnitude_sched_pkg.sv
// Shared types and constants for the magnitude scheduler.
package magnitude_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Default axis / magnitude width.
    localparam int DATA_W_DEF = 16;

    // Requester identifiers.
    localparam logic ID_ACC = 1'b0;
    localparam logic ID_GYR = 1'b1;

    // Default engine watchdog limit in cycles.
    localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage : magnitude_sched_pkg

// File: rtl/magnitude_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from two
// valids and the ID granted last time.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // A lone valid wins; on a tie the requester not granted last wins.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule : rr_arb2

// File: rtl/magnitude_sched.sv
// Round-robin scheduler sharing one vector-magnitude engine between the
// accelerometer (ID 0) and gyroscope (ID 1) requesters.
// Optional feature: define MAG_TIMEOUT_EN to enable the engine watchdog,
// which aborts a WAIT lasting TIMEOUT_CYCLES with res_err=1 and an
// all-ones magnitude. Without it WAIT holds indefinitely and res_err is 0.
module magnitude_sched
    import magnitude_sched_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic [DATA_W-1:0] req0_z,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    input  logic [DATA_W-1:0] req1_z,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_x,
    output logic [DATA_W-1:0] eng_y,
    output logic [DATA_W-1:0] eng_z,
    input  logic [DATA_W-1:0] eng_magnitude,
    input  logic              eng_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [DATA_W-1:0] res_magnitude,
    output logic              res_err
);

    state_e            state_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] eng_x_q;
    logic [DATA_W-1:0] eng_y_q;
    logic [DATA_W-1:0] eng_z_q;
    logic              eng_start_q;
    logic              res_valid_q;
    logic              res_id_q;
    logic [DATA_W-1:0] res_mag_q;

    logic [1:0]        grant_s;
    logic              grant_id_s;
    logic              in_idle_s;
    logic              accept_s;
    logic [DATA_W-1:0] sel_x_s;
    logic [DATA_W-1:0] sel_y_s;
    logic [DATA_W-1:0] sel_z_s;
    logic              wd_expired_s;

`ifdef MAG_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             res_err_q;

    // The count holds the number of completed WAIT cycles; the last one fires.
    assign wd_expired_s = (wd_cnt_q == CNT_LAST);
    assign res_err      = res_err_q;
`else
    logic unused_timeout_s;

    // Watchdog absent: WAIT never expires and no abort is reported.
    assign wd_expired_s     = 1'b0;
    assign res_err          = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s)
    );

    // Ready is offered only in IDLE and stays low while reset is held.
    assign in_idle_s  = (state_q == ST_IDLE) && reset_n;
    assign req0_ready = in_idle_s && grant_s[0];
    assign req1_ready = in_idle_s && grant_s[1];
    assign accept_s   = req0_ready || req1_ready;
    assign grant_id_s = grant_s[1] ? ID_GYR : ID_ACC;

    // Steer the granted requester's axes toward the operand registers.
    always_comb begin
        sel_x_s = req0_x;
        sel_y_s = req0_y;
        sel_z_s = req0_z;
        if (grant_s[1]) begin
            sel_x_s = req1_x;
            sel_y_s = req1_y;
            sel_z_s = req1_z;
        end else begin
            sel_x_s = req0_x;
            sel_y_s = req0_y;
            sel_z_s = req0_z;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            eng_x_q      <= {DATA_W{1'b0}};
            eng_y_q      <= {DATA_W{1'b0}};
            eng_z_q      <= {DATA_W{1'b0}};
            eng_start_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_mag_q    <= {DATA_W{1'b0}};
`ifdef MAG_TIMEOUT_EN
            wd_cnt_q     <= {CNT_W{1'b0}};
            res_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        eng_x_q      <= sel_x_s;
                        eng_y_q      <= sel_y_s;
                        eng_z_q      <= sel_z_s;
                        res_id_q     <= grant_id_s;
                        last_grant_q <= grant_id_s;
                        eng_start_q  <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Engine valid is deliberately not looked at here.
                    eng_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
`ifdef MAG_TIMEOUT_EN
                    wd_cnt_q    <= {CNT_W{1'b0}};
`endif
                end
                ST_WAIT: begin
                    if (eng_valid) begin
                        res_mag_q   <= eng_magnitude;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
`ifdef MAG_TIMEOUT_EN
                        res_err_q   <= 1'b0;
`endif
                    end else if (wd_expired_s) begin
                        res_mag_q   <= {DATA_W{1'b1}};
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
`ifdef MAG_TIMEOUT_EN
                        res_err_q   <= 1'b1;
`endif
                    end else begin
`ifdef MAG_TIMEOUT_EN
                        wd_cnt_q    <= wd_cnt_q + CNT_W'(1);
`endif
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    eng_start_q <= 1'b0;
                    res_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng_start     = eng_start_q;
    assign eng_x         = eng_x_q;
    assign eng_y         = eng_y_q;
    assign eng_z         = eng_z_q;
    assign res_valid     = res_valid_q;
    assign res_id        = res_id_q;
    assign res_magnitude = res_mag_q;

endmodule : magnitude_sched
